reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- In-order retirement buffer directly downstream of the renamer.
- Accepts one renamed instruction per cycle, recording the overwritten PRNs (mapping_inputs_*) and returning a ROB tag.
- Tracks out-of-order completion by tag and commits at most one instruction per cycle in program order.
- On commit, returns the committed instruction's old PRNs to the renamer free list over its free_valid/free_prns lanes.

Parameters:
- ROB_ENTRIES, 32, number of entries; must be a power of two.
- PRN_BITS, 6, physical register number width.
- MAX_OPERANDS, 3, destination lanes per instruction; equals renamer free-lane count.
- NUM_COMPLETE, 2, number of completion ports from the execution units.
- TAG_BITS, $clog2(ROB_ENTRIES), ROB tag width; derived.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- alloc_valid  in  1  dispatch requests an entry (renamer mapping_valid && input_valid).
- alloc_ready  out  1  ROB can accept an allocation this cycle.
- alloc_old_valid[MAX_OPERANDS]  in  1  lane holds an overwritten PRN to free at commit.
- alloc_old_prn[MAX_OPERANDS]  in  PRN_BITS  overwritten PRN per lane.
- alloc_tag  out  TAG_BITS  tag given to the allocating instruction (current tail index).
- complete_valid[NUM_COMPLETE]  in  1  execution unit finished an instruction.
- complete_tag[NUM_COMPLETE]  in  TAG_BITS  tag of the finished instruction.
- commit_valid  out  1  head instruction retires this cycle.
- commit_tag  out  TAG_BITS  tag of the retiring instruction.
- free_valid[MAX_OPERANDS]  out  1  to renamer: lane frees a PRN.
- free_prns[MAX_OPERANDS]  out  PRN_BITS  to renamer: PRN being freed.
- rob_count  out  TAG_BITS+1  occupied entries.

Behaviour:
- Storage and pointers:
  - Circular array of entries {valid, done, old_valid[MO], old_prn[MO]}.
  - head and tail pointers are TAG_BITS+1 wide; the MSB is the wrap bit.
  - rob_count = tail - head, computed modulo 2^(TAG_BITS+1).
  - Full when count == ROB_ENTRIES; empty when head == tail.
- Reset:
  - head = tail = 0; every entry's valid and done cleared.
  - Consequently alloc_ready=1, commit_valid=0, all free_valid=0, rob_count=0, alloc_tag=0.
  - Reset wins over any alloc, complete or commit in the same cycle.
  - Reset mid-operation discards all in-flight entries; their PRNs are not freed. Renamer/free list are reset alongside.
- Allocation:
  - alloc_ready = !full. It is combinational and must not depend on alloc_valid or on commit in the same cycle; a full ROB stalls even if the head commits that cycle.
  - alloc_tag = tail[TAG_BITS-1:0] every cycle.
  - On alloc_valid && alloc_ready at the edge: entry[tail] gets valid=1, done=0 and the old_* fields latched; tail increments.
- Completion:
  - At the edge, each complete_valid lane with a valid target entry sets done=1.
  - Completion to an invalid entry is ignored and prints $display ERROR.
  - Duplicate tags across lanes in one cycle are legal and idempotent.
- Commit (combinational from registered state):
  - commit_valid = entry[head].valid && entry[head].done.
  - free_valid[i] = commit_valid && entry[head].old_valid[i]; free_prns[i] = entry[head].old_prn[i].
  - At the edge when commit_valid: entry[head].valid=0, done=0; head increments.
  - When commit_valid=0, free_prns are don't-care and free_valid=0.
- Latency:
  - Allocate in cycle N; earliest completion in N+1; the completed entry commits in N+2 at the earliest.
  - A completion arriving for the head in cycle C is visible as commit_valid in C+1. Completions are not forwarded into commit.
- Simultaneous events:
  - Alloc and commit in the same cycle: both apply; count unchanged.
  - Commit on the last entry plus alloc when count=1: both apply.
  - Completion for the entry being committed is impossible (its done is already set) and has no effect.
- Wrap-around: pointers wrap naturally; the tag is the low bits, so tags are reused only after the entry is freed.
- No flush/recovery in this revision; mispredict recovery is a later block.

Decomposition:
- foxtrot_pkg holds the rob_entry_t struct (valid, done, old_valid[], old_prn[]) and the ROB_ENTRIES/TAG_BITS constants, so dispatch and execution units share the tag width.
- Single module; no sub-module is warranted. Pointer and count logic are inline.

Test Plan:
- Reset, then 32 allocs with no completions: tags 0..31 in order; alloc_ready drops to 0 after the 32nd; rob_count=32; 33rd alloc_valid is ignored.
- Alloc tag0 (old PRNs 5,—,9) and tag1 (old PRN 7); complete tag1 then tag0 one cycle later: commit_valid only after tag0 is done. Commits are in order: cycle k frees {5,9} with free_valid={1,0,1}; cycle k+1 frees {7}.
- Full ROB, head complete, alloc_valid held: commit this cycle, alloc_ready=0; next cycle alloc_ready=1 and allocation gets tag = old head tag (wrap).
- Both complete lanes target the same tag, plus a completion for an unallocated tag: the entry is done once; the stray completion prints an ERROR and leaves state unchanged.
- Steady state: alloc + complete + commit every cycle for 100 cycles; rob_count stays constant and pointers wrap at least 3 times with no lost frees.
- rst asserted with 10 entries live: next cycle rob_count=0, commit_valid=0, free_valid all 0, alloc_tag=0.

Source files
------------

// File: rtl/foxtrot_pkg.sv
// rtl/foxtrot_pkg.sv - shared ROB sizing constants and entry layout
package foxtrot_pkg;

    localparam int ROB_ENTRIES  = 32;
    localparam int PRN_BITS     = 6;
    localparam int MAX_OPERANDS = 3;
    localparam int NUM_COMPLETE = 2;
    localparam int TAG_BITS     = $clog2(ROB_ENTRIES);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PTR_BITS     = TAG_BITS + 1;

    typedef struct packed {
        logic                                   valid;
        logic                                   done;
        logic [MAX_OPERANDS-1:0]                old_valid;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  old_prn;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer returning overwritten PRNs at commit
module reorder_buffer
    import foxtrot_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                alloc_valid_i,
    output logic                                alloc_ready_o,
    input  logic [MAX_OPERANDS-1:0]             alloc_old_valid_i,
    input  logic [MAX_OPERANDS*PRN_BITS-1:0]    alloc_old_prn_i,
    output logic [TAG_BITS-1:0]                 alloc_tag_o,
    input  logic [NUM_COMPLETE-1:0]             complete_valid_i,
    input  logic [NUM_COMPLETE*TAG_BITS-1:0]    complete_tag_i,
    output logic                                commit_valid_o,
    output logic [TAG_BITS-1:0]                 commit_tag_o,
    output logic [MAX_OPERANDS-1:0]             free_valid_o,
    output logic [MAX_OPERANDS*PRN_BITS-1:0]    free_prns_o,
    output logic [PTR_BITS-1:0]                 rob_count_o
);

    localparam logic [PTR_BITS-1:0] PTR_ONE    = PTR_BITS'(1);
    localparam logic [PTR_BITS-1:0] FULL_COUNT = PTR_BITS'(ROB_ENTRIES);

    rob_entry_t              entries_q [ROB_ENTRIES];
    rob_entry_t              entries_d [ROB_ENTRIES];
    logic [PTR_BITS-1:0]     head_q, head_d;
    logic [PTR_BITS-1:0]     tail_q, tail_d;
    logic [PTR_BITS-1:0]     count;
    logic [TAG_BITS-1:0]     head_idx;
    logic [TAG_BITS-1:0]     tail_idx;
    logic                    full;
    logic                    commit_valid;
    logic                    alloc_fire;
    logic [NUM_COMPLETE-1:0] stray_complete;

    assign head_idx      = head_q[TAG_BITS-1:0];
    assign tail_idx      = tail_q[TAG_BITS-1:0];
    assign count         = tail_q - head_q;
    assign full          = (count == FULL_COUNT);
    // Readiness looks only at registered occupancy, so a full ROB stalls even while the head retires.
    assign alloc_ready_o = !full;
    assign alloc_fire    = alloc_valid_i && !full;
    assign alloc_tag_o   = tail_idx;
    assign rob_count_o   = count;

    // Head retires once its completion has been registered; completions are never forwarded.
    assign commit_valid   = entries_q[head_idx].valid && entries_q[head_idx].done;
    assign commit_valid_o = commit_valid;
    assign commit_tag_o   = head_idx;

    // Present the head entry's overwritten PRNs to the free list lanes.
    always_comb begin
        free_valid_o = '0;
        free_prns_o  = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            free_valid_o[i]                      = commit_valid && entries_q[head_idx].old_valid[i];
            free_prns_o[i*PRN_BITS +: PRN_BITS]  = entries_q[head_idx].old_prn[i];
        end
    end

    // Next state: mark completions, retire the head, then append the new allocation at the tail.
    always_comb begin
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        stray_complete = '0;
        for (int l = 0; l < NUM_COMPLETE; l++) begin
            if (complete_valid_i[l]) begin
                if (entries_q[complete_tag_i[l*TAG_BITS +: TAG_BITS]].valid) begin
                    entries_d[complete_tag_i[l*TAG_BITS +: TAG_BITS]].done = 1'b1;
                end else begin
                    stray_complete[l] = 1'b1;
                end
            end
        end
        if (commit_valid) begin
            entries_d[head_idx].valid = 1'b0;
            entries_d[head_idx].done  = 1'b0;
            head_d                    = head_q + PTR_ONE;
        end
        if (alloc_fire) begin
            entries_d[tail_idx].valid     = 1'b1;
            entries_d[tail_idx].done      = 1'b0;
            entries_d[tail_idx].old_valid = alloc_old_valid_i;
            entries_d[tail_idx].old_prn   = alloc_old_prn_i;
            tail_d                        = tail_q + PTR_ONE;
        end
    end

    // State register; reset drops every in-flight entry without freeing its PRNs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                entries_q[e] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
        end
    end

`ifndef SYNTHESIS
    // Report completions that target an entry not currently allocated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int l = 0; l < NUM_COMPLETE; l++) begin
                if (stray_complete[l]) begin
                    $display("ERROR: reorder_buffer completion lane %0d for unallocated tag %0d",
                             l, complete_tag_i[l*TAG_BITS +: TAG_BITS]);
                end
            end
        end
    end
`endif

endmodule
